// File: rtl/ntt_host_sequencer.sv
// ntt_host_sequencer: command-driven sequencer for the NTT engine's
// load_w / load_data / start / start_intt protocol. It bridges valid/ready
// host streams onto the core's single-word din/dout port.
// Optional feature macro: NTT_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog
// (err_code 3) and the TIMEOUT parameter that sizes it.

module ntt_host_sequencer #(
    parameter int DATA_W    = 64,
    parameter int RING_SIZE = 4096,
    parameter int GAP       = 5
`ifdef NTT_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT   = 65536
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              ntt_load_w,
    output logic              ntt_load_data,
    output logic              ntt_start,
    output logic              ntt_start_intt,
    output logic [DATA_W-1:0] ntt_din,
    input  logic              ntt_done,
    input  logic [DATA_W-1:0] ntt_dout
);

    localparam int CNT_W = $clog2(2 * RING_SIZE + 2);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_W-1:0] TW_LAST   = CNT_W'(2 * RING_SIZE);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SIZE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);

`ifdef NTT_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        IDLE,
        TW_PULSE,
        TW_STREAM,
        DATA_PULSE,
        DATA_STREAM,
        GAP_WAIT,
        START,
        WAIT_DONE,
        DRAIN,
        ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tw_loaded;
    logic             loading_tw;
    logic             is_intt;

`ifdef NTT_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt;
`endif

    // Status flags are pure decodes of the state register; cmd_ready is also
    // masked by reset so it reads 0 while reset is held and 1 the cycle after.
    assign cmd_ready = (state == IDLE) && !reset;
    assign in_ready  = (state == TW_STREAM) || (state == DATA_STREAM);
    assign busy      = (state != IDLE);
    assign error     = (state == ERR);

    // Main sequencer: state, counters, protocol pulses and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            gap_cnt        <= '0;
            tw_loaded      <= 1'b0;
            loading_tw     <= 1'b0;
            is_intt        <= 1'b0;
            err_code       <= 2'd0;
            ntt_load_w     <= 1'b0;
            ntt_load_data  <= 1'b0;
            ntt_start      <= 1'b0;
            ntt_start_intt <= 1'b0;
            ntt_din        <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_last       <= 1'b0;
`ifdef NTT_SEQ_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            ntt_load_w     <= 1'b0;
            ntt_load_data  <= 1'b0;
            ntt_start      <= 1'b0;
            ntt_start_intt <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;

            case (state)
                IDLE: begin
                    ntt_din <= '0;
                    if (cmd_valid) begin
                        cnt <= '0;
                        if (cmd_op == 2'd0) begin
                            loading_tw <= 1'b1;
                            state      <= TW_PULSE;
                        end else if (cmd_op == 2'd3 || !tw_loaded) begin
                            err_code <= 2'd2;
                            state    <= ERR;
                        end else begin
                            loading_tw <= 1'b0;
                            is_intt    <= (cmd_op == 2'd2);
                            state      <= DATA_PULSE;
                        end
                    end
                end

                // The pulse lands in the first stream cycle so the first word
                // reaches ntt_din exactly one cycle after it.
                TW_PULSE: begin
                    ntt_load_w <= 1'b1;
                    state      <= TW_STREAM;
                end

                DATA_PULSE: begin
                    ntt_load_data <= 1'b1;
                    state         <= DATA_STREAM;
                end

                // The core's loader cannot stall, so a missing word is fatal.
                TW_STREAM, DATA_STREAM: begin
                    if (!in_valid) begin
                        err_code <= 2'd1;
                        ntt_din  <= '0;
                        state    <= ERR;
                    end else begin
                        ntt_din <= in_data;
                        cnt     <= cnt + CNT_W'(1);
                        if ((state == TW_STREAM   && cnt == TW_LAST) ||
                            (state == DATA_STREAM && cnt == RING_LAST)) begin
                            gap_cnt <= '0;
                            state   <= GAP_WAIT;
                        end
                    end
                end

                GAP_WAIT: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    if (gap_cnt == GAP_LAST) begin
                        if (loading_tw) begin
                            tw_loaded <= 1'b1;
                            ntt_din   <= '0;
                            state     <= IDLE;
                        end else begin
                            state <= START;
                        end
                    end
                end

                START: begin
                    ntt_start      <= !is_intt;
                    ntt_start_intt <= is_intt;
`ifdef NTT_SEQ_TIMEOUT_EN
                    to_cnt         <= '0;
`endif
                    state          <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (ntt_done) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end
`ifdef NTT_SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        err_code <= 2'd3;
                        ntt_din  <= '0;
                        state    <= ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end

                // dout is captured every cycle and replayed one cycle later.
                DRAIN: begin
                    out_valid <= 1'b1;
                    out_data  <= ntt_dout;
                    out_last  <= (cnt == RING_LAST);
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == RING_LAST) begin
                        ntt_din <= '0;
                        state   <= IDLE;
                    end
                end

                ERR: begin
                    ntt_din <= '0;
                end

                default: begin
                    ntt_din <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_host_sequencer.sv
// tb_ntt_host_sequencer: directed bench for ntt_host_sequencer with
// RING_SIZE=8 and GAP=5. Define NTT_SEQ_TIMEOUT_EN to build the watchdog
// variant with TIMEOUT=20.

module tb_ntt_host_sequencer;

    localparam int DATA_W = 64;
    localparam int RING   = 8;
    localparam int GAP    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              error;
    logic [1:0]        err_code;
    logic              ntt_load_w;
    logic              ntt_load_data;
    logic              ntt_start;
    logic              ntt_start_intt;
    logic [DATA_W-1:0] ntt_din;
    logic              ntt_done;
    logic [DATA_W-1:0] ntt_dout;

    int checks = 0;
    int passes = 0;

    ntt_host_sequencer #(
        .DATA_W(DATA_W),
        .RING_SIZE(RING),
        .GAP(GAP)
`ifdef NTT_SEQ_TIMEOUT_EN
       ,.TIMEOUT(20)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .error(error),
        .err_code(err_code),
        .ntt_load_w(ntt_load_w),
        .ntt_load_data(ntt_load_data),
        .ntt_start(ntt_start),
        .ntt_start_intt(ntt_start_intt),
        .ntt_din(ntt_din),
        .ntt_done(ntt_done),
        .ntt_dout(ntt_dout)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyReset;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        ntt_done  = 1'b0;
        ntt_dout  = '0;
        tick;
        tick;
        reset = 1'b0;
        #1;
    endtask

    // LOAD_TW with words 1..17, checking pulse, din sequence and gap timing.
    task automatic applyLoadTw;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        tick;
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd1;
        tick;
        checkOutput("tw_load_w_pulse", ntt_load_w, 1);
        checkOutput("tw_in_ready", in_ready, 1);
        for (int i = 1; i <= 2 * RING + 1; i++) begin
            tick;
            checkOutput($sformatf("tw_din%0d", i), ntt_din, 64'(i));
            checkOutput("tw_load_w_low", ntt_load_w, 0);
            if (i < 2 * RING + 1) in_data = 64'(i + 1);
            else in_valid = 1'b0;
        end
        checkOutput("tw_gap_in_ready", in_ready, 0);
        for (int g = 0; g < GAP - 1; g++) begin
            tick;
            checkOutput("tw_gap_cmd_ready", cmd_ready, 0);
        end
        tick;
        checkOutput("tw_cmd_ready_back", cmd_ready, 1);
        checkOutput("tw_error", error, 0);
        checkOutput("tw_din_idle", ntt_din, 0);
    endtask

    // NTT/INTT data load of 0x10..0x17; drop_at < RING drops that word.
    task automatic applyData(input logic [1:0] op, input int drop_at);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick;
        cmd_valid = 1'b0;
        tick;
        checkOutput("data_load_pulse", ntt_load_data, 1);
        checkOutput("data_in_ready", in_ready, 1);
        for (int k = 0; k < RING; k++) begin
            if (k == drop_at) begin
                in_valid = 1'b0;
                tick;
                checkOutput("underrun_error", error, 1);
                checkOutput("underrun_code", err_code, 1);
                checkOutput("underrun_in_ready", in_ready, 0);
                checkOutput("underrun_din", ntt_din, 0);
                for (int t = 0; t < 10; t++) begin
                    tick;
                    checkOutput("underrun_no_start", ntt_start | ntt_start_intt, 0);
                end
                return;
            end
            in_valid = 1'b1;
            in_data  = 64'h10 + 64'(k);
            tick;
            checkOutput($sformatf("data_din%0d", k), ntt_din, 64'h10 + 64'(k));
        end
        in_valid = 1'b0;
        for (int g = 0; g < GAP; g++) begin
            tick;
            checkOutput("gap_no_start", ntt_start | ntt_start_intt, 0);
            checkOutput("gap_din_hold", ntt_din, 64'h17);
        end
        tick;
        checkOutput("start_fwd", ntt_start, (op == 2'd1) ? 64'd1 : 64'd0);
        checkOutput("start_inv", ntt_start_intt, (op == 2'd2) ? 64'd1 : 64'd0);
        checkOutput("wait_busy", busy, 1);
    endtask

    // Raise done now, feed 0xA0.. and check outputs; reset after reset_after words.
    task automatic applyDrain(input int reset_after);
        tick;
        ntt_done = 1'b1;
        tick;
        ntt_done = 1'b0;
        ntt_dout = 64'hA0;
        checkOutput("drain_first_quiet", out_valid, 0);
        for (int i = 0; i < RING; i++) begin
            tick;
            checkOutput($sformatf("out_valid%0d", i), out_valid, 1);
            checkOutput($sformatf("out_data%0d", i), out_data, 64'hA0 + 64'(i));
            checkOutput($sformatf("out_last%0d", i), out_last, (i == RING - 1) ? 64'd1 : 64'd0);
            ntt_dout = 64'hA1 + 64'(i);
            if (i + 1 == reset_after) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                #1;
                checkOutput("rst_drain_out_valid", out_valid, 0);
                checkOutput("rst_drain_busy", busy, 0);
                checkOutput("rst_drain_cmd_ready", cmd_ready, 1);
                return;
            end
        end
        tick;
        checkOutput("drain_done_valid", out_valid, 0);
        checkOutput("drain_done_busy", busy, 0);
        checkOutput("drain_done_cmd_ready", cmd_ready, 1);
    endtask

    task automatic expectCmdError(input logic [1:0] op, input string tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        checkOutput({tag, "_cmd_ready_pre"}, cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
        checkOutput({tag, "_error"}, error, 1);
        checkOutput({tag, "_code"}, err_code, 2);
        checkOutput({tag, "_busy"}, busy, 1);
        for (int t = 0; t < 3; t++) begin
            tick;
            checkOutput({tag, "_no_pulse"}, ntt_load_data | ntt_load_w | ntt_start | ntt_start_intt, 0);
            checkOutput({tag, "_cmd_ready"}, cmd_ready, 0);
            checkOutput({tag, "_in_ready"}, in_ready, 0);
        end
    endtask

    // Directed sequence.
    initial begin
        $display("[TB] starting ntt_host_sequencer directed test");
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        ntt_done  = 1'b0;
        ntt_dout  = '0;
        tick;
        tick;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_err_code", err_code, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_din", ntt_din, 0);
        checkOutput("rst_pulses", ntt_load_w | ntt_load_data | ntt_start | ntt_start_intt, 0);
        reset = 1'b0;
        #1;

        // INTT with no twiddles loaded.
        expectCmdError(2'd2, "no_tw");

        // Full LOAD_TW, NTT, drain; then INTT, drain.
        applyReset;
        applyLoadTw;
        applyData(2'd1, RING);
        applyDrain(RING + 1);
        applyData(2'd2, RING);
        applyDrain(RING + 1);

        // Illegal opcode with twiddles present.
        expectCmdError(2'd3, "illegal_op");

        // Underrun on word 4.
        applyReset;
        applyLoadTw;
        applyData(2'd1, 4);

        // Done never arrives.
        applyReset;
        applyLoadTw;
        applyData(2'd1, RING);
`ifdef NTT_SEQ_TIMEOUT_EN
        for (int t = 1; t < 20; t++) tick;
        checkOutput("timeout_not_yet", error, 0);
        tick;
        checkOutput("timeout_error", error, 1);
        checkOutput("timeout_code", err_code, 3);
        checkOutput("timeout_busy", busy, 1);
`else
        for (int t = 0; t < 60; t++) tick;
        checkOutput("no_timeout_busy", busy, 1);
        checkOutput("no_timeout_error", error, 0);
`endif

        // Reset in the middle of DRAIN clears tw_loaded.
        applyReset;
        applyLoadTw;
        applyData(2'd1, RING);
        applyDrain(3);
        expectCmdError(2'd1, "after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
